// File: rtl/video_capture_pkg.sv
// video_capture_pkg: shared token/FSM types and token width helper
// Contents:
//   tok_type_e - token kind carried in the upper two bits of each FIFO word
//   state_e    - capture FSM states
//   tok_width  - FIFO word width for a given colour channel width
package video_capture_pkg;
    typedef enum logic [1:0] {
        TOK_PIX   = 2'b00,
        TOK_LINE  = 2'b01,
        TOK_FRAME = 2'b10
    } tok_type_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SKIP,
        S_CAPTURE,
        S_DONE
    } state_e;

    function automatic int tok_width(input int color_w);
        return 2 + 3 * color_w;
    endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through synchronous FIFO
// Ports:
//   clk, rst      - clock, synchronous active-high reset (empties the FIFO)
//   push, push_data - write request; ignored when full unless a pop happens too
//   pop           - read request; ignored when empty
//   pop_data      - head word, zero while empty
//   count         - number of stored words (0..DEPTH)
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_pop, do_push;

    assign do_pop   = pop && count != 0;
    // a pop in the same cycle frees the slot, so a full FIFO still accepts
    assign do_push  = push && (count != (AW+1)'(DEPTH) || do_pop);
    assign pop_data = count != 0 ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/video_capture.sv
// video_capture: turns pixel/line/frame strobes into a token stream
// Ports:
//   clk_main, reset         - system clock, synchronous active-high reset
//   pix_en, nhbk, hvot      - pixel clock level, line blank (low), frame end (low)
//   video_r/g/b             - pixel colour, sampled on the pixel edge cycle
//   arm                     - 1 runs skip/capture, 0 returns to idle
//   tok_ready, tok_valid    - token handshake
//   tok_type, tok_data      - token kind and {r,g,b} payload (zero for LINE/FRAME)
//   overflow                - sticky, a token was dropped
//   done, frame_cnt         - capture finished, frames captured since arm
import video_capture_pkg::*;
module video_capture #(
    parameter int COLOR_W     = 6,
    parameter int FIFO_DEPTH  = 16,
    parameter int SKIP_FRAMES = 1,
    parameter int NUM_FRAMES  = 1
) (
    input  logic                   clk_main,
    input  logic                   reset,
    input  logic                   pix_en,
    input  logic                   nhbk,
    input  logic                   hvot,
    input  logic [COLOR_W-1:0]     video_r,
    input  logic [COLOR_W-1:0]     video_g,
    input  logic [COLOR_W-1:0]     video_b,
    input  logic                   arm,
    input  logic                   tok_ready,
    output logic                   tok_valid,
    output logic [1:0]             tok_type,
    output logic [3*COLOR_W-1:0]   tok_data,
    output logic                   overflow,
    output logic                   done,
    output logic [7:0]             frame_cnt
);
    localparam int DW = 3 * COLOR_W;
    localparam int TW = tok_width(COLOR_W);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_e          state, state_n;
    logic [3:0]      skip, skip_n;
    logic [7:0]      cnt_n;
    logic            pix_q, nhbk_q, hvot_q, primed;
    logic            pe, le, fe, cap;
    logic [TW-1:0]   pend [2];
    logic [TW-1:0]   pend_n [2];
    logic [1:0]      pend_v, pend_v_n;
    logic [TW-1:0]   cand [5];
    logic [4:0]      cand_v;
    logic [2:0]      n;
    logic            push, drop, full;
    logic [TW-1:0]   push_tok, fifo_out;
    logic [CW-1:0]   fifo_count;

    // primed masks a frame edge that would otherwise appear if hvot is low at reset release
    assign pe  = primed & pix_en & ~pix_q;
    assign le  = primed & nhbk & ~nhbk_q;
    assign fe  = primed & ~hvot & hvot_q;
    assign cap = arm && state == S_CAPTURE;

    // older pending tokens go first, then new events in FRAME, LINE, PIX order;
    // the first goes to the FIFO, the next two are held, anything beyond is lost
    always_comb begin
        cand[0]     = pend[0];
        cand[1]     = pend[1];
        cand[2]     = {TOK_FRAME, {DW{1'b0}}};
        cand[3]     = {TOK_LINE, {DW{1'b0}}};
        cand[4]     = {TOK_PIX, video_r, video_g, video_b};
        cand_v      = {cap & pe, cap & le, cap & fe, pend_v[1], pend_v[0]};
        push        = 1'b0;
        push_tok    = '0;
        pend_n[0]   = '0;
        pend_n[1]   = '0;
        pend_v_n    = '0;
        drop        = 1'b0;
        n           = '0;
        for (int i = 0; i < 5; i++)
            if (cand_v[i]) begin
                if (n == 0) begin
                    push     = 1'b1;
                    push_tok = cand[i];
                end else if (n == 1) begin
                    pend_n[0]   = cand[i];
                    pend_v_n[0] = 1'b1;
                end else if (n == 2) begin
                    pend_n[1]   = cand[i];
                    pend_v_n[1] = 1'b1;
                end else
                    drop = 1'b1;
                n = n + 3'd1;
            end
    end

    always_comb begin
        state_n = state;
        skip_n  = skip;
        cnt_n   = frame_cnt;
        case (state)
            S_IDLE:
                if (arm) begin
                    state_n = SKIP_FRAMES > 0 ? S_SKIP : S_CAPTURE;
                    skip_n  = '0;
                    cnt_n   = '0;
                end
            S_SKIP:
                if (fe) begin
                    skip_n = skip + 4'd1;
                    if ({1'b0, skip} + 5'd1 == 5'(SKIP_FRAMES))
                        state_n = S_CAPTURE;
                end
            S_CAPTURE:
                if (fe) begin
                    cnt_n = frame_cnt == 8'hFF ? frame_cnt : frame_cnt + 8'd1;
                    if (NUM_FRAMES != 0 && {1'b0, frame_cnt} + 9'd1 == 9'(NUM_FRAMES))
                        state_n = S_DONE;
                end
            default: ;
        endcase
        if (!arm)
            state_n = S_IDLE;
    end

    assign full = fifo_count == CW'(FIFO_DEPTH);

    always_ff @(posedge clk_main) begin
        if (reset) begin
            state     <= S_IDLE;
            skip      <= '0;
            frame_cnt <= '0;
            pix_q     <= 1'b1;
            nhbk_q    <= 1'b1;
            hvot_q    <= 1'b1;
            primed    <= 1'b0;
            pend_v    <= '0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_n;
            skip      <= skip_n;
            frame_cnt <= cnt_n;
            pix_q     <= pix_en;
            nhbk_q    <= nhbk;
            hvot_q    <= hvot;
            primed    <= 1'b1;
            pend_v    <= pend_v_n;
            pend[0]   <= pend_n[0];
            pend[1]   <= pend_n[1];
            overflow  <= overflow | drop | (push & full & ~tok_ready);
        end
    end

    sync_fifo #(.WIDTH(TW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk_main),
        .rst       (reset),
        .push      (push),
        .push_data (push_tok),
        .pop       (tok_ready),
        .pop_data  (fifo_out),
        .count     (fifo_count)
    );

    assign tok_valid = fifo_count != 0;
    assign tok_type  = fifo_out[TW-1 -: 2];
    assign tok_data  = fifo_out[DW-1:0];
    assign done      = state == S_DONE;
endmodule

// File: tb/tb_video_capture.sv
// tb_video_capture: directed, table-driven and randomized checks of video_capture
module tb_video_capture;
    import video_capture_pkg::*;

    logic clk_main = 1'b0;
    always #5 clk_main = ~clk_main;

    logic        reset, pix_en, nhbk, hvot, arm_a, arm_b, ready_a, ready_b;
    logic [5:0]  vr, vg, vb;
    logic        valid_a, valid_b, ovf_a, ovf_b, done_a, done_b;
    logic [1:0]  type_a, type_b;
    logic [17:0] data_a, data_b;
    logic [7:0]  fc_a, fc_b;

    video_capture dut_a (
        .clk_main(clk_main), .reset(reset), .pix_en(pix_en), .nhbk(nhbk), .hvot(hvot),
        .video_r(vr), .video_g(vg), .video_b(vb), .arm(arm_a), .tok_ready(ready_a),
        .tok_valid(valid_a), .tok_type(type_a), .tok_data(data_a), .overflow(ovf_a),
        .done(done_a), .frame_cnt(fc_a)
    );

    video_capture #(.FIFO_DEPTH(4), .SKIP_FRAMES(0), .NUM_FRAMES(0)) dut_b (
        .clk_main(clk_main), .reset(reset), .pix_en(pix_en), .nhbk(nhbk), .hvot(hvot),
        .video_r(vr), .video_g(vg), .video_b(vb), .arm(arm_b), .tok_ready(ready_b),
        .tok_valid(valid_b), .tok_type(type_b), .tok_data(data_b), .overflow(ovf_b),
        .done(done_b), .frame_cnt(fc_b)
    );

    typedef logic [19:0] tok_t;
    typedef struct {
        logic       pix, nh, hv;
        logic [5:0] r, g, b;
        logic       ev;
        logic [1:0] ty;
        logic [17:0] d;
    } vec_t;

    int   tests = 0, fails = 0, nf;
    tok_t qa[$], qb[$], ea[$];
    vec_t tbl[9];

    always @(negedge clk_main) begin
        if (valid_a && ready_a) qa.push_back({type_a, data_a});
        if (valid_b && ready_b) qb.push_back({type_b, data_b});
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk_main);
            #1;
        end
    endtask

    task automatic pixel(input logic [5:0] r, input logic [5:0] g, input logic [5:0] b);
        vr = r; vg = g; vb = b;
        pix_en = 1'b1; step();
        pix_en = 1'b0; step();
    endtask

    task automatic gen_frame(input int lines, input int px, input bit ex);
        for (int l = 0; l < lines; l++) begin
            nhbk = 1'b1; step();
            if (ex) ea.push_back({2'b01, 18'd0});
            for (int p = 0; p < px; p++) begin
                pixel(6'(l), 6'(p), 6'h07);
                if (ex) ea.push_back({2'b00, 6'(l), 6'(p), 6'h07});
            end
            nhbk = 1'b0; step();
        end
        hvot = 1'b0; step();
        if (ex) ea.push_back({2'b10, 18'd0});
        hvot = 1'b1; step(2);
    endtask

    task automatic cmp_q(input string name);
        chk({name, "_count"}, qa.size(), ea.size());
        for (int i = 0; i < ea.size() && i < qa.size(); i++)
            chk(name, qa[i], ea[i]);
    endtask

    // reference model for dut_a: token lists as queues, progress as plain counters
    localparam int MD = 16, MS = 1, MN = 1;
    tok_t mf[$], mp[$];
    int   m_ph, m_sk, m_fc;
    bit   m_ovf, m_pix, m_nh, m_hv, m_pr;

    task automatic model_reset();
        mf.delete(); mp.delete();
        m_ph = 0; m_sk = 0; m_fc = 0; m_ovf = 0;
        m_pix = 1; m_nh = 1; m_hv = 1; m_pr = 0;
    endtask

    task automatic model_step();
        bit   fe, le, pe, cap, pop, full;
        tok_t cand[$];
        tok_t t;
        fe  = m_pr && m_hv && !hvot;
        le  = m_pr && !m_nh && nhbk;
        pe  = m_pr && !m_pix && pix_en;
        cap = arm_a && m_ph == 2;
        cand = mp;
        mp.delete();
        if (cap && fe) cand.push_back({2'b10, 18'd0});
        if (cap && le) cand.push_back({2'b01, 18'd0});
        if (cap && pe) cand.push_back({2'b00, vr, vg, vb});
        full = mf.size() == MD;
        pop  = ready_a && mf.size() > 0;
        if (pop) void'(mf.pop_front());
        if (cand.size() > 0) begin
            t = cand.pop_front();
            if (full && !pop) m_ovf = 1; else mf.push_back(t);
        end
        while (cand.size() > 0) begin
            t = cand.pop_front();
            if (mp.size() < 2) mp.push_back(t); else m_ovf = 1;
        end
        if (!arm_a) m_ph = 0;
        else if (m_ph == 0) begin
            m_sk = 0; m_fc = 0; m_ph = MS > 0 ? 1 : 2;
        end else if (m_ph == 1 && fe) begin
            m_sk++;
            if (m_sk == MS) m_ph = 2;
        end else if (m_ph == 2 && fe) begin
            m_fc = m_fc < 255 ? m_fc + 1 : 255;
            if (MN != 0 && m_fc == MN) m_ph = 3;
        end
        m_pix = pix_en; m_nh = nhbk; m_hv = hvot; m_pr = 1;
    endtask

    task automatic chk_model();
        logic [30:0] e;
        e = {mf.size() > 0, mf.size() > 0 ? mf[0] : 20'd0, m_ovf, m_ph == 3, 8'(m_fc)};
        chk("model", {1'b0, valid_a, type_a, data_a, ovf_a, done_a, fc_a}, {1'b0, e});
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b0, 1'b1, 6'h01, 6'h02, 6'h03, 1'b1, 2'b00, 18'h01083};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 6'h00, 6'h00, 6'h00, 1'b0, 2'b00, 18'h00000};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 6'h3F, 6'h00, 6'h15, 1'b1, 2'b01, 18'h00000};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 6'h11, 6'h22, 6'h33, 1'b1, 2'b00, 18'h3F015};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 6'h00, 6'h00, 6'h00, 1'b1, 2'b10, 18'h00000};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 6'h0A, 6'h0B, 6'h0C, 1'b1, 2'b01, 18'h00000};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 6'h2A, 6'h2B, 6'h2C, 1'b1, 2'b00, 18'h0A2CC};
        tbl[7] = '{1'b1, 1'b1, 1'b0, 6'h00, 6'h00, 6'h00, 1'b1, 2'b10, 18'h00000};
        tbl[8] = '{1'b0, 1'b0, 1'b1, 6'h00, 6'h00, 6'h00, 1'b0, 2'b00, 18'h00000};

        reset = 1; pix_en = 0; nhbk = 0; hvot = 1; arm_a = 0; arm_b = 0;
        ready_a = 1; ready_b = 1; vr = 0; vg = 0; vb = 0;
        step(3);
        chk("rst_valid", valid_a, 0);
        chk("rst_type", type_a, 0);
        chk("rst_data", data_a, 0);
        chk("rst_ovf", ovf_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_fcnt", fc_a, 0);
        chk("rst_state", dut_a.state, S_IDLE);
        reset = 0; step();

        // one skipped frame then one captured 2x4 frame
        qa.delete(); ea.delete();
        arm_a = 1; step(3);
        gen_frame(2, 4, 0);
        gen_frame(2, 4, 1);
        step(4);
        cmp_q("frame_tokens");
        chk("frame_done", done_a, 1);
        chk("frame_fcnt", fc_a, 1);

        // disarm mid-frame, then re-arm must skip again before capturing
        arm_a = 0; step(2);
        chk("disarm_idle", dut_a.state, S_IDLE);
        chk("disarm_done", done_a, 0);
        qa.delete(); ea.delete();
        arm_a = 1; step(2);
        gen_frame(1, 2, 0);
        nhbk = 1; step();
        ea.push_back({2'b01, 18'd0});
        pixel(6'd1, 6'd2, 6'd3);
        ea.push_back({2'b00, 6'd1, 6'd2, 6'd3});
        arm_a = 0; step();
        pixel(6'd4, 6'd5, 6'd6);
        nhbk = 0; step(); nhbk = 1; step();
        hvot = 0; step(); hvot = 1; step();
        nhbk = 0; step();
        chk("disarm_fcnt", fc_a, 0);
        arm_a = 1; step(2);
        gen_frame(1, 2, 0);
        gen_frame(1, 2, 1);
        step(4);
        cmp_q("rearm_tokens");
        chk("rearm_fcnt", fc_a, 1);
        chk("rearm_done", done_a, 1);
        arm_a = 0;

        // table: coincident events on the continuous, no-skip instance
        qb.delete();
        arm_b = 1; ready_b = 1; step(3);
        for (int i = 0; i < 9; i++) begin
            pix_en = tbl[i].pix; nhbk = tbl[i].nh; hvot = tbl[i].hv;
            vr = tbl[i].r; vg = tbl[i].g; vb = tbl[i].b;
            step();
            chk($sformatf("tbl%0d_valid", i), valid_b, tbl[i].ev);
            if (tbl[i].ev) chk($sformatf("tbl%0d_tok", i), {type_b, data_b}, {tbl[i].ty, tbl[i].d});
        end
        chk("tbl_ovf", ovf_b, 0);

        // continuous mode keeps counting frames
        hvot = 0; step(); hvot = 1; step(2);
        chk("cont_fcnt", fc_b, 3);
        chk("cont_done", done_b, 0);
        nf = 0;
        foreach (qb[i]) if (qb[i][19:18] == 2'b10) nf++;
        chk("cont_frames", nf, 3);

        // FIFO of 4 stalled with 6 pixels
        ready_b = 0; step();
        qb.delete();
        for (int i = 0; i < 6; i++) begin
            pixel(6'(i), 6'(i + 8), 6'(i + 16));
            if (i == 3) chk("ovf_at_full", ovf_b, 0);
        end
        chk("ovf_set", ovf_b, 1);
        chk("fifo_held", dut_b.u_fifo.count, 4);
        ready_b = 1; step(8);
        chk("drain_count", qb.size(), 4);
        for (int i = 0; i < 4 && i < qb.size(); i++)
            chk($sformatf("drain%0d", i), qb[i], {2'b00, 6'(i), 6'(i + 8), 6'(i + 16)});

        // reset mid-line with three queued tokens
        ready_b = 0;
        nhbk = 1; step();
        pixel(6'h01, 6'h01, 6'h01);
        pixel(6'h02, 6'h02, 6'h02);
        chk("pre_rst_queued", dut_b.u_fifo.count, 3);
        reset = 1; step(); reset = 0;
        chk("post_rst_valid", valid_b, 0);
        chk("post_rst_fcnt", fc_b, 0);
        chk("post_rst_state", dut_b.state, S_IDLE);
        chk("post_rst_ovf", ovf_b, 0);
        arm_b = 0; nhbk = 0; step();

        // randomized run of dut_a against the reference model
        reset = 1; arm_a = 1; ready_a = 1; step(2);
        model_reset();
        reset = 0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(99) == 0) arm_a = ~arm_a;
            if ($urandom_range(15) == 0) ready_a = ~ready_a;
            if ($urandom_range(1) == 0) pix_en = ~pix_en;
            if ($urandom_range(7) == 0) nhbk = ~nhbk;
            if ($urandom_range(11) == 0) hvot = ~hvot;
            vr = 6'($urandom); vg = 6'($urandom); vb = 6'($urandom);
            model_step();
            step();
            chk_model();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/video_capture.md
VIDEO_CAPTURE -- requirements
Module: video_capture

Interface
REQ-001 Parameter COLOR_W, default 6: bits per colour channel.
REQ-002 Parameter FIFO_DEPTH, default 16, power of two >= 4: token FIFO entries.
REQ-003 Parameter SKIP_FRAMES, default 1, range 0..15: frames discarded after arm.
REQ-004 Parameter NUM_FRAMES, default 1, range 0..255: frames captured; 0 means continuous until disarm.
REQ-005 clk_main  in  1  system clock, ~24 MHz.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 pix_en  in  1  pixel clock level (V6M); rising edge marks a pixel.
REQ-008 nhbk  in  1  horizontal blank, active-low; rising edge marks line start.
REQ-009 hvot  in  1  frame-end strobe, active-low; falling edge marks frame end.
REQ-010 video_r, video_g, video_b  in  COLOR_W each  pixel colour.
REQ-011 arm  in  1  level; 1 starts/continues capture, 0 aborts to IDLE.
REQ-012 tok_ready  in  1  downstream accepts token.
REQ-013 tok_valid  out  1  token available.
REQ-014 tok_type  out  2  00 PIX, 01 LINE, 10 FRAME, 11 unused.
REQ-015 tok_data  out  3*COLOR_W  {r,g,b} for PIX; zero for LINE/FRAME.
REQ-016 overflow  out  1  sticky: a token was dropped.
REQ-017 done  out  1  NUM_FRAMES frames captured.
REQ-018 frame_cnt  out  8  frames captured since arm.

Function
REQ-019 Edge detection SHALL use one registered copy of each of pix_en, nhbk, hvot; the first cycle after reset SHALL see no edge.
REQ-020 FSM states SHALL be IDLE, SKIP, CAPTURE, DONE.
REQ-021 IDLE -> SKIP when arm=1 and SKIP_FRAMES>0; IDLE -> CAPTURE when arm=1 and SKIP_FRAMES=0.
REQ-022 SKIP SHALL count frame-end edges and go to CAPTURE on the SKIP_FRAMES-th; no tokens generated in SKIP.
REQ-023 In CAPTURE, each frame-end edge SHALL push FRAME and increment frame_cnt; on reaching NUM_FRAMES (nonzero) go to DONE.
REQ-024 DONE SHALL hold done=1, push nothing, and return to IDLE when arm=0.
REQ-025 arm=0 in any state SHALL return to IDLE next cycle; FIFO contents remain drainable; frame_cnt cleared on next arm.
REQ-026 In CAPTURE, line edge SHALL push LINE; pixel edge SHALL push PIX with colour sampled in the edge-detect cycle.
REQ-027 Same-cycle events SHALL be ordered FRAME, LINE, PIX; one push per cycle, deferred tokens held in a 2-entry pending register drained on following cycles.
REQ-028 Pixel data SHALL be captured at edge time, never at deferred push time.
REQ-029 FIFO transfer when tok_valid & tok_ready; first-word-fall-through, push-to-tok_valid latency 1 cycle.
REQ-030 Push while FIFO full SHALL drop that token and set overflow; simultaneous pop and push on full SHALL succeed without overflow.
REQ-031 Pending register overflow (third deferred event) SHALL drop the newest and set overflow.
REQ-032 frame_cnt SHALL saturate at 255 in continuous mode.

Reset
REQ-033 Reset SHALL force IDLE, empty FIFO and pending register, tok_valid=0, tok_type=0, tok_data=0, overflow=0, done=0, frame_cnt=0, edge registers to current-input-neutral (pix_en 1, nhbk 1, hvot 1).
REQ-034 Reset mid-capture SHALL discard all queued tokens; no token emitted the cycle after reset.

Structure
REQ-035 Package video_capture_pkg SHALL hold token-type enum, FSM state enum, and token width function.
REQ-036 FIFO SHALL be a separate sub-module sync_fifo (parametrised width/depth, count output).

Verification
REQ-037 SKIP_FRAMES=1, NUM_FRAMES=1, 2 lines x 4 pixels per frame, tok_ready=1 -> frame 1 silent; then LINE,4 PIX,LINE,4 PIX,FRAME; done=1, frame_cnt=1.
REQ-038 Pixel edge and line edge same cycle with colour 0x3F/0x00/0x15 -> LINE then PIX with tok_data 0x3F015 (6-bit packing), no overflow.
REQ-039 FIFO_DEPTH=4, tok_ready=0, 6 pixels -> 4 tokens held, overflow=1; release ready -> exactly 4 PIX in order.
REQ-040 NUM_FRAMES=0, 3 frames -> 3 FRAME tokens, frame_cnt=3, done stays 0.
REQ-041 Reset asserted mid-line with 3 tokens queued -> next cycle tok_valid=0, frame_cnt=0, state IDLE.
REQ-042 arm dropped mid-frame -> no further tokens; re-arm restarts skip count from 0.
